// File: rtl/b16regbank8_wr_pkg.sv
// rtl/b16regbank8_wr_pkg.sv - shared constants and state type for the 8 x 16-bit register bank write side
package b16regbank8_wr_pkg;

    localparam int REG_W    = 16;
    localparam int NUM_REGS = 8;
    localparam int SEL_W    = $clog2(NUM_REGS);

    localparam logic [REG_W-1:0] RESET_VAL_DEF = 16'h0000;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/b16regbank8_wr_b16reg.sv
// rtl/b16regbank8_wr_b16reg.sv - single bank register with write enable and async reset to a parameter value
module b16reg
    import b16regbank8_wr_pkg::*;
#(
    parameter int             W       = REG_W,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/b16regbank8_wr.sv
// rtl/b16regbank8_wr.sv - bank write port with valid/ready handshake and 8-cycle clear; REG0_ZERO_EN hard-wires register 0
module b16regbank8_wr
    import b16regbank8_wr_pkg::*;
#(
    parameter logic [REG_W-1:0] RESET_VAL = RESET_VAL_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [SEL_W-1:0]          wr_sel,
    input  logic [REG_W-1:0]          wr_data,
    input  logic                      clr_req,
    output logic                      busy,
    output logic [REG_W*NUM_REGS-1:0] regs_out
);

`ifdef REG0_ZERO_EN
    localparam bit REG0_ZERO = 1'b1;
`else
    localparam bit REG0_ZERO = 1'b0;
`endif

    state_t           state;
    state_t           state_next;
    logic [SEL_W-1:0] cnt;
    logic             wr_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= (state == CLEAR) ? cnt + SEL_W'(1) : '0;
        end
    end

    // clr_req is only looked at in IDLE, so a request during CLEAR neither restarts nor extends it
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (clr_req) state_next = CLEAR;
            CLEAR:   if (cnt == SEL_W'(NUM_REGS - 1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        wr_ready = (state == IDLE);
        busy     = (state == CLEAR);
    end

    assign wr_acc = wr_valid && wr_ready;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (REG0_ZERO && i == 0) begin : g_zero
            assign regs_out[REG_W*i +: REG_W] = '0;
        end else begin : g_ff
            logic             en;
            logic [REG_W-1:0] d;

            // write and clear never coincide: writes need IDLE, clear steps need CLEAR
            assign en = (wr_acc && wr_sel == SEL_W'(i)) || (busy && cnt == SEL_W'(i));
            assign d  = busy ? RESET_VAL : wr_data;

            b16reg #(
                .W       (REG_W),
                .RST_VAL (RESET_VAL)
            ) u_reg (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (en),
                .d     (d),
                .q     (regs_out[REG_W*i +: REG_W])
            );
        end
    end

endmodule

// File: tb/tb_b16regbank8_wr.sv
// tb/tb_b16regbank8_wr.sv - scoreboard bench for b16regbank8_wr
module tb_b16regbank8_wr;

`ifdef REG0_ZERO_EN
    localparam bit Z0 = 1'b1;
`else
    localparam bit Z0 = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         wr_valid;
    logic         wr_ready;
    logic [2:0]   wr_sel;
    logic [15:0]  wr_data;
    logic         clr_req;
    logic         busy;
    logic [127:0] regs_out;

    b16regbank8_wr dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_sel   (wr_sel),
        .wr_data  (wr_data),
        .clr_req  (clr_req),
        .busy     (busy),
        .regs_out (regs_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] regs;
        logic         ready;
        logic         busy;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    logic [15:0] m_regs [8];
    logic        m_busy;
    logic [2:0]  m_cnt;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
        m_busy = 1'b0;
        m_cnt  = 3'd0;
    endtask

    function automatic logic [127:0] model_pack();
        logic [127:0] v;
        for (int i = 0; i < 8; i++) v[16*i +: 16] = (Z0 && i == 0) ? 16'h0000 : m_regs[i];
        return v;
    endfunction

    // advance the model by one edge using the currently driven inputs, then run the edge and compare
    task automatic cycle();
        exp_t e;
        exp_t o;
        if (!m_busy) begin
            if (wr_valid && !(Z0 && wr_sel == 3'd0)) m_regs[wr_sel] = wr_data;
            if (clr_req) begin
                m_busy = 1'b1;
                m_cnt  = 3'd0;
            end
        end else begin
            m_regs[m_cnt] = 16'h0000;
            if (m_cnt == 3'd7) m_busy = 1'b0;
            m_cnt = m_cnt + 3'd1;
        end
        e.regs  = model_pack();
        e.ready = !m_busy;
        e.busy  = m_busy;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 1'b1, 1'b0);
        end else begin
            o = sb.pop_front();
            check("regs_out", regs_out, o.regs);
            check("wr_ready", wr_ready, o.ready);
            check("busy", busy, o.busy);
        end
    endtask

    logic [127:0] exp_v;
    int           n_busy;
    int           n_aaaa;

    initial begin
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_sel   = 3'd0;
        wr_data  = 16'h0000;
        clr_req  = 1'b0;
        model_reset();

        // reset held for two edges
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_regs", regs_out, 128'h0);
        check("rst_ready", wr_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;

        // write all registers, one per cycle
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1'b1;
            wr_sel   = 3'(i);
            wr_data  = 16'h1000 + 16'(i);
            cycle();
            check($sformatf("wr_reg%0d", i), regs_out[16*i +: 16],
                  (Z0 && i == 0) ? 16'h0000 : 16'h1000 + 16'(i));
        end
        wr_valid = 1'b0;
        exp_v = {16'h1007, 16'h1006, 16'h1005, 16'h1004, 16'h1003, 16'h1002, 16'h1001, 16'h1000};
        if (Z0) exp_v[15:0] = 16'h0000;
        check("wr_all", regs_out, exp_v);

        // clear pulse with a blocked write held during the clear
        clr_req = 1'b1;
        cycle();
        clr_req  = 1'b0;
        wr_valid = 1'b1;
        wr_sel   = 3'd5;
        wr_data  = 16'hBEEF;
        check("clr_busy_start", busy, 1'b1);
        n_busy = busy ? 1 : 0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (!busy) break;
            n_busy++;
            if (n_busy == 4)
                check("clr_mid", regs_out,
                      {16'h1007, 16'h1006, 16'h1005, 16'h1004, 16'h1003, 48'h0});
        end
        check("clr_len", 32'(n_busy), 32'd8);
        check("clr_end_regs", regs_out, 128'h0);
        check("clr_end_ready", wr_ready, 1'b1);
        cycle();
        wr_valid = 1'b0;
        check("blocked_wr", regs_out[80 +: 16], 16'hBEEF);

        // simultaneous write and clear request
        wr_valid = 1'b1;
        wr_sel   = 3'd6;
        wr_data  = 16'hAAAA;
        clr_req  = 1'b1;
        cycle();
        wr_valid = 1'b0;
        clr_req  = 1'b0;
        n_aaaa = (regs_out[96 +: 16] == 16'hAAAA) ? 1 : 0;
        for (int k = 0; k < 9; k++) begin
            cycle();
            if (regs_out[96 +: 16] == 16'hAAAA) n_aaaa++;
        end
        check("simul_hold", 32'(n_aaaa), 32'd7);
        check("simul_done", busy, 1'b0);
        check("simul_regs", regs_out, 128'h0);

        // reset in the middle of a clear
        wr_valid = 1'b1;
        wr_sel   = 3'd3;
        wr_data  = 16'h1234;
        cycle();
        wr_valid = 1'b0;
        clr_req  = 1'b1;
        cycle();
        clr_req = 1'b0;
        for (int k = 0; k < 3; k++) cycle();
        check("pre_rst_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst_regs", regs_out, 128'h0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_ready", wr_ready, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) cycle();
        check("no_resume", busy, 1'b0);

        // register 0 write
        wr_valid = 1'b1;
        wr_sel   = 3'd0;
        wr_data  = 16'hFFFF;
        cycle();
        wr_valid = 1'b0;
        check("reg0_wr", regs_out[15:0], Z0 ? 16'h0000 : 16'hFFFF);
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
